// File: rtl/mdio_arbiter.sv
// Round-robin arbiter/sequencer sharing one MDIO station-management master among NUM_REQ clients.
// Optional WAIT watchdog enabled by defining MDIO_TIMEOUT_EN.
module mdio_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [5*NUM_REQ-1:0]  req_phyaddr,
  input  logic [5*NUM_REQ-1:0]  req_regaddr,
  input  logic [16*NUM_REQ-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_err,
  output logic [15:0]           rsp_data,
  output logic                  m_start_stb,
  output logic [1:0]            m_st,
  output logic [1:0]            m_op,
  output logic [4:0]            m_phyaddr,
  output logic [4:0]            m_regaddr,
  output logic [15:0]           m_wr_data,
  input  logic                  m_done,
  input  logic [15:0]           m_rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ-1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, grant, sel_idx;
  logic [IDX_W:0]   cand;
  logic             sel_found;
  logic [1:0]       sel_op;
  logic             op_legal;
  logic [1:0]       op_q;
  logic [4:0]       phy_q, reg_q;
  logic [15:0]      wd_q, data_q;
  logic             err_q;
  logic             timed_out;

`ifdef MDIO_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES-1);
  logic [TO_W-1:0] to_cnt;

  // Held at zero outside WAIT, so it restarts on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) to_cnt <= '0;
    else                      to_cnt <= to_cnt + 1'b1;
  end

  assign timed_out = (state == WAIT) && (to_cnt == TO_LAST);
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  // Scan downward so the lowest offset from rr_ptr wins without an early exit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (req_valid[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign sel_op   = req_op[int'(sel_idx)*2 +: 2];
  assign op_legal = (sel_op == 2'b01) || (sel_op == 2'b10);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (sel_found) state_nxt = op_legal ? ISSUE : RESP;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (m_done || timed_out) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      grant  <= '0;
      op_q   <= '0;
      phy_q  <= '0;
      reg_q  <= '0;
      wd_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sel_found) begin
          grant  <= sel_idx;
          rr_ptr <= (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
          op_q   <= sel_op;
          phy_q  <= req_phyaddr[int'(sel_idx)*5 +: 5];
          reg_q  <= req_regaddr[int'(sel_idx)*5 +: 5];
          wd_q   <= req_wr_data[int'(sel_idx)*16 +: 16];
          err_q  <= !op_legal;
          data_q <= '0;
        end
        WAIT: if (m_done) begin
          data_q <= (op_q == 2'b10) ? m_rd_data : 16'h0000;
          err_q  <= 1'b0;
        end else if (timed_out) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    m_start_stb = (state == ISSUE);
    rsp_err     = (state == RESP) && err_q;
    rsp_data    = (state == RESP && !err_q) ? data_q : 16'h0000;
    // Gated by rst so a visible ready always means the request is taken.
    if (state == IDLE && sel_found && !rst) req_ready[sel_idx] = 1'b1;
    if (state == RESP)                      rsp_valid[grant]   = 1'b1;
  end

  assign m_st      = 2'b01;
  assign m_op      = op_q;
  assign m_phyaddr = phy_q;
  assign m_regaddr = reg_q;
  assign m_wr_data = wd_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Randomized self-checking bench for mdio_arbiter against a transaction-level round-robin model.
module tb_mdio_arbiter;

  localparam int N = 4;
`ifdef MDIO_TIMEOUT_EN
  localparam int TO = 15;
`else
  localparam int TO = 1023;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op;
  logic [5*N-1:0]  req_phyaddr;
  logic [5*N-1:0]  req_regaddr;
  logic [16*N-1:0] req_wr_data;
  logic [N-1:0]    rsp_valid;
  logic            rsp_err;
  logic [15:0]     rsp_data;
  logic            m_start_stb;
  logic [1:0]      m_st, m_op;
  logic [4:0]      m_phyaddr, m_regaddr;
  logic [15:0]     m_wr_data;
  logic            m_done = 1'b0;
  logic [15:0]     m_rd_data = '0;

  logic [1:0]  f_op  [N];
  logic [4:0]  f_phy [N];
  logic [4:0]  f_reg [N];
  logic [15:0] f_wd  [N];

  int checks = 0;
  int errors = 0;
  int model_rr = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_op = '0; req_phyaddr = '0; req_regaddr = '0; req_wr_data = '0;
    for (int i = 0; i < N; i++) begin
      req_op[i*2 +: 2]       = f_op[i];
      req_phyaddr[i*5 +: 5]  = f_phy[i];
      req_regaddr[i*5 +: 5]  = f_reg[i];
      req_wr_data[i*16 +: 16] = f_wd[i];
    end
  end

  mdio_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_phyaddr(req_phyaddr), .req_regaddr(req_regaddr), .req_wr_data(req_wr_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .m_start_stb(m_start_stb), .m_st(m_st), .m_op(m_op), .m_phyaddr(m_phyaddr),
    .m_regaddr(m_regaddr), .m_wr_data(m_wr_data), .m_done(m_done), .m_rd_data(m_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // First valid requester at or after the model pointer, wrapping.
  function automatic int pick(input logic [N-1:0] pat);
    for (int k = 0; k < N; k++)
      if (pat[(model_rr + k) % N]) return (model_rr + k) % N;
    return -1;
  endfunction

  task automatic scramble_fields(input logic legal_only);
    for (int i = 0; i < N; i++) begin
      int r = $urandom_range(0, 9);
      f_op[i]  = (legal_only || r > 1) ? 2'($urandom_range(1, 2)) : (r == 0 ? 2'b00 : 2'b11);
      f_phy[i] = 5'($urandom);
      f_reg[i] = 5'($urandom);
      f_wd[i]  = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; m_done = 1'b0;
    @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_start", m_start_stb, 0);
    check("rst_m_st", m_st, 2'b01);
    check("rst_m_op", m_op, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    model_rr = 0;
  endtask

  // One complete transaction starting from IDLE; master answers after delay WAIT cycles.
  task automatic txn(input logic [N-1:0] pat, input logic hold, input int delay, input logic [15:0] rd);
    int g;
    logic [1:0] op; logic [4:0] phy, rg; logic [15:0] wd;
    @(negedge clk);
    req_valid = pat;
    #1;
    g = pick(pat);
    check("ready_grant", req_ready, 32'(1) << g);
    check("idle_rsp_valid", rsp_valid, 0);
    op = f_op[g]; phy = f_phy[g]; rg = f_reg[g]; wd = f_wd[g];
    model_rr = (g + 1) % N;
    @(negedge clk);
    if (!hold) req_valid = '0;
    scramble_fields(1'b0);
    #1;
    check("ready_busy", req_ready, 0);
    if (op == 2'b01 || op == 2'b10) begin
      check("start", m_start_stb, 1);
      check("m_op", m_op, op);
      check("m_phy", m_phyaddr, phy);
      check("m_reg", m_regaddr, rg);
      check("m_wd", m_wr_data, wd);
      for (int d = 1; d <= delay; d++) begin
        @(negedge clk);
        if (d == delay) begin m_done = 1'b1; m_rd_data = rd; end
        #1;
        check("wait_start", m_start_stb, 0);
        check("wait_rsp", rsp_valid, 0);
        check("wait_ready", req_ready, 0);
        check("wait_fields", {m_op, m_phyaddr, m_regaddr, m_wr_data}, {op, phy, rg, wd});
      end
      @(negedge clk);
      m_done = 1'b0; m_rd_data = 16'($urandom);
      #1;
      check("rsp_valid", rsp_valid, 32'(1) << g);
      check("rsp_err", rsp_err, 0);
      check("rsp_data", rsp_data, (op == 2'b10) ? rd : 16'h0000);
      check("resp_ready", req_ready, 0);
    end else begin
      check("illegal_nostart", m_start_stb, 0);
      check("illegal_rsp_valid", rsp_valid, 32'(1) << g);
      check("illegal_err", rsp_err, 1);
      check("illegal_data", rsp_data, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    scramble_fields(1'b1);
    do_reset();

    // Directed read on requester 1.
    f_op[1] = 2'b10; f_phy[1] = 5'h03; f_reg[1] = 5'h01;
    txn(4'b0010, 1'b0, 3, 16'h796D);

    // Directed write on requester 0.
    f_op[0] = 2'b01; f_wd[0] = 16'h1200;
    txn(4'b0001, 1'b0, 2, 16'hAAAA);

    // Rotation with everyone continuously valid.
    do_reset();
    for (int t = 0; t < 8; t++) begin
      scramble_fields(1'b1);
      check("rotate_order", 32'(pick(4'b1111)), 32'(t % 4));
      txn(4'b1111, 1'b1, $urandom_range(1, 4), 16'($urandom));
    end

    // Illegal OP on requester 2.
    do_reset();
    scramble_fields(1'b1);
    f_op[2] = 2'b11;
    txn(4'b0100, 1'b0, 1, 16'h0);

    // Reset during WAIT, coinciding with m_done.
    scramble_fields(1'b1);
    @(negedge clk); req_valid = 4'b1000;
    @(negedge clk); req_valid = '0;
    @(negedge clk); rst = 1'b1; m_done = 1'b1; m_rd_data = 16'hBEEF;
    @(negedge clk); m_done = 1'b0;
    #1;
    check("wrst_rsp_valid", rsp_valid, 0);
    check("wrst_start", m_start_stb, 0);
    check("wrst_fields", {m_op, m_phyaddr, m_regaddr, m_wr_data}, 0);
    check("wrst_m_st", m_st, 2'b01);
    check("wrst_rsp", {rsp_err, rsp_data}, 0);
    rst = 1'b0; model_rr = 0;
    @(negedge clk); m_done = 1'b1;
    @(negedge clk); m_done = 1'b0;
    #1;
    check("late_done_rsp", rsp_valid, 0);
    check("late_done_start", m_start_stb, 0);
    txn(4'b1111, 1'b0, 2, 16'h1234);

    // Randomized traffic with occasional idle cycles.
    for (int t = 0; t < 40; t++) begin
      scramble_fields(1'b0);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk); req_valid = '0; #1;
        check("no_req_ready", req_ready, 0);
      end
      txn(N'($urandom_range(1, 15)), 1'($urandom), $urandom_range(1, 6), 16'($urandom));
    end

`ifdef MDIO_TIMEOUT_EN
    do_reset();
    scramble_fields(1'b1);
    f_op[1] = 2'b10;
    @(negedge clk); req_valid = 4'b0010; #1;
    check("to_ready", req_ready, 4'b0010);
    @(negedge clk); req_valid = '0; #1;
    check("to_start", m_start_stb, 1);
    for (int w = 1; w <= TO; w++) begin
      @(negedge clk); #1;
      check("to_waiting", rsp_valid, 0);
    end
    @(negedge clk); #1;
    check("to_rsp_valid", rsp_valid, 4'b0010);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_data", rsp_data, 0);
    @(negedge clk); m_done = 1'b1; m_rd_data = 16'hFFFF; #1;
    check("to_late_idle", rsp_valid, 0);
    @(negedge clk); m_done = 1'b0; #1;
    check("to_late_rsp", {rsp_valid, rsp_err}, 0);
    model_rr = 2;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
